voting_machine: RTL and testbench

Four-candidate electronic voting machine core with an 8-bit LED display. Each candidate button is qualified by a hold filter, so only a sustained press registers exactly one vote. Votes are tallied in per-candidate saturating counters. A mode input selects the LED view: vote-acknowledge flash in voting mode, or a candidate's tally in result mode. The block sits at board top level, between the push-button/switch inputs and the LED bank.

---
 rtl/voting_pkg.sv | 19 +
 rtl/vote_button_ctrl.sv | 34 +++
 rtl/voting_machine.sv | 96 +++++++++
 tb/tb_voting_machine.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared constants and helpers for the voting machine
package voting_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int COUNT_W        = 8;

    localparam logic [7:0] LED_FLASH = 8'hFF;
    localparam logic [7:0] LED_OFF   = 8'h00;

    typedef enum logic {
        MODE_VOTE   = 1'b0,
        MODE_RESULT = 1'b1
    } mode_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vote_button_ctrl.sv
// rtl/vote_button_ctrl.sv - button hold filter producing one vote pulse per sustained press
module vote_button_ctrl #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic valid_vote
);

    localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_valid_vote;

    // Saturating at HOLD_MAX means the pulse condition can only be met once per press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt   <= '0;
            r_valid_vote <= 1'b0;
        end else if (!button) begin
            r_hold_cnt   <= '0;
            r_valid_vote <= 1'b0;
        end else begin
            if (r_hold_cnt != HOLD_MAX)
                r_hold_cnt <= r_hold_cnt + 1'b1;
            r_valid_vote <= (r_hold_cnt == HOLD_MAX - 1'b1);
        end
    end

    assign valid_vote = r_valid_vote;

endmodule

// File: rtl/voting_machine.sv
// rtl/voting_machine.sv - four-candidate voting core with tally counters and LED display
module voting_machine
    import voting_pkg::*;
#(
    parameter int HOLD_CYCLES  = 10,
    parameter int FLASH_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [7:0] led
);

    localparam int FLASH_W = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

    logic [NUM_CANDIDATES-1:0] w_buttons;
    logic [NUM_CANDIDATES-1:0] w_valid_vote;
    logic                      w_result_mode;
    logic                      w_vote_accept;
    logic [FLASH_W-1:0]        w_flash_next;
    logic [COUNT_W-1:0]        w_sel_count;
    logic [7:0]                w_led_next;

    logic [COUNT_W-1:0]        r_count [NUM_CANDIDATES];
    logic [FLASH_W-1:0]        r_flash_cnt;
    logic [7:0]                r_led;

    assign w_buttons     = {button4, button3, button2, button1};
    assign w_result_mode = (mode == MODE_RESULT);
    assign w_vote_accept = !w_result_mode && (|w_valid_vote);

    genvar g;
    generate
        for (g = 0; g < NUM_CANDIDATES; g++) begin : g_btn
            vote_button_ctrl #(
                .HOLD_CYCLES (HOLD_CYCLES)
            ) u_btn (
                .clk        (clk),
                .reset      (reset),
                .button     (w_buttons[g]),
                .valid_vote (w_valid_vote[g])
            );
        end
    endgenerate

    always_comb begin
        w_flash_next = '0;
        if (w_result_mode)
            w_flash_next = '0;
        else if (w_vote_accept)
            w_flash_next = FLASH_LOAD;
        else if (r_flash_cnt != '0)
            w_flash_next = r_flash_cnt - 1'b1;
    end

    // Scan lowest priority first so button1 ends up winning.
    always_comb begin
        w_sel_count = LED_OFF;
        for (int i = NUM_CANDIDATES - 1; i >= 0; i--) begin
            if (w_buttons[i])
                w_sel_count = r_count[i];
        end
    end

    always_comb begin
        w_led_next = LED_OFF;
        if (w_result_mode)
            w_led_next = w_sel_count;
        else if (w_flash_next != '0)
            w_led_next = LED_FLASH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CANDIDATES; i++)
                r_count[i] <= '0;
            r_flash_cnt <= '0;
            r_led       <= LED_OFF;
        end else begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                if (!w_result_mode && w_valid_vote[i])
                    r_count[i] <= sat_inc(r_count[i]);
            end
            r_flash_cnt <= w_flash_next;
            r_led       <= w_led_next;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_voting_machine.sv
// tb/tb_voting_machine.sv - directed scoreboard bench for voting_machine
module tb_voting_machine;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       button1, button2, button3, button4;
    logic [7:0] led;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    voting_machine #(
        .HOLD_CYCLES  (10),
        .FLASH_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .button1 (button1),
        .button2 (button2),
        .button3 (button3),
        .button4 (button4),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_buttons(input logic [3:0] b);
        {button4, button3, button2, button1} = b;
    endtask

    task automatic expect_led(input logic [7:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_led();
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        assert (led === e) n_pass++;
        else $error("FAIL %s: led=%02h expected=%02h", t, led, e);
    endtask

    task automatic cyc_check(input logic [7:0] e, input string t);
        expect_led(e, t);
        tick();
        check_led();
    endtask

    // Buttons high for 'hold' edges in voting mode; a vote lights the LEDs on steps 11..20.
    task automatic press_vote(input logic [3:0] b, input int hold, input string t);
        int n;
        n = ((hold > 10) ? hold : 10) + 12;
        mode = 1'b0;
        set_buttons(b);
        for (int i = 1; i <= n; i++) begin
            cyc_check((hold >= 10 && i >= 11 && i <= 20) ? 8'hFF : 8'h00, t);
            if (i == hold)
                set_buttons(4'b0000);
        end
    endtask

    task automatic show(input logic [3:0] b, input logic [7:0] e, input string t);
        mode = 1'b1;
        set_buttons(b);
        cyc_check(e, t);
        set_buttons(4'b0000);
        cyc_check(8'h00, {t, "_rel"});
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        set_buttons(4'b0000);
        repeat (3) tick();
        cyc_check(8'h00, "reset");
        reset = 1'b0;

        press_vote(4'b0001, 1, "short");
        show(4'b0001, 8'd0, "short_count");

        press_vote(4'b0001, 20, "single");
        show(4'b0001, 8'd1, "single_count");

        press_vote(4'b0110, 20, "simul");
        show(4'b0110, 8'd1, "simul_prio");
        show(4'b0100, 8'd1, "simul_c3");

        press_vote(4'b0010, 9, "nine");
        show(4'b0010, 8'd1, "nine_count");
        press_vote(4'b1000, 10, "ten");

        mode = 1'b1;
        set_buttons(4'b1000);
        for (int i = 0; i < 20; i++)
            cyc_check(8'd1, "ignored");
        set_buttons(4'b0000);
        cyc_check(8'h00, "ignored_rel");
        show(4'b1000, 8'd1, "c4_after");

        press_vote(4'b0001, 300, "long");
        press_vote(4'b0001, 20, "repress");
        show(4'b0001, 8'd3, "long_count");
        show(4'b1111, 8'd3, "prio_all");
        show(4'b1110, 8'd1, "prio_234");

        mode = 1'b0;
        set_buttons(4'b0100);
        for (int i = 1; i <= 12; i++)
            cyc_check((i >= 11) ? 8'hFF : 8'h00, "midflash");
        set_buttons(4'b0001);
        reset = 1'b1;
        cyc_check(8'h00, "reset_led");
        reset = 1'b0;
        press_vote(4'b0001, 10, "post_reset");
        show(4'b0001, 8'd1, "post_reset_c1");
        show(4'b0100, 8'd0, "post_reset_c3");
        show(4'b0010, 8'd0, "post_reset_c2");

        mode = 1'b0;
        for (int k = 0; k < 256; k++) begin
            set_buttons(4'b0001);
            repeat (10) tick();
            set_buttons(4'b0000);
            tick();
        end
        repeat (12) tick();
        show(4'b0001, 8'd255, "saturate");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
